// File: rtl/branch_sched.sv
// Multi-cycle conditional-branch resolver: latches a request, compares the operands,
// computes the next PC, trains a 2-bit saturating BHT and returns the result.
module branch_sched #(
  parameter int unsigned N           = 32,
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [N-1:0] req_pc_i,
  input  logic [N-1:0] req_a_i,
  input  logic [N-1:0] req_b_i,
  input  logic [N-1:0] req_imm_i,
  input  logic [2:0]   req_ctrl_i,
  input  logic         req_pred_i,
  input  logic [N-1:0] lookup_pc_i,
  output logic         lookup_taken_o,
  output logic         resp_valid_o,
  input  logic         resp_ready_i,
  output logic         resp_taken_o,
  output logic [N-1:0] resp_target_o,
  output logic         resp_mispredict_o,
  output logic         resp_illegal_o
);

  localparam logic [2:0] COMP_EQ  = 3'b000;
  localparam logic [2:0] COMP_NE  = 3'b001;
  localparam logic [2:0] COMP_LT  = 3'b100;
  localparam logic [2:0] COMP_GE  = 3'b101;
  localparam logic [2:0] COMP_LTU = 3'b110;
  localparam logic [2:0] COMP_GEU = 3'b111;

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);
  localparam logic [N-1:0] PcStep = {{(N-3){1'b0}}, 3'b100};

  typedef enum logic [1:0] {StIdle, StEval, StResp} state_e;

  state_e state_q, state_d;

  logic [N-1:0] pc_q, a_q, b_q, imm_q;
  logic [2:0]   ctrl_q;
  logic         pred_q;

  logic [1:0] bht_q [BHT_ENTRIES];
  logic [1:0] bht_d [BHT_ENTRIES];

  logic         resp_taken_q, resp_mispredict_q, resp_illegal_q;
  logic [N-1:0] resp_target_q;

  logic            cond_taken, cond_illegal;
  logic [N-1:0]    target;
  logic [IdxW-1:0] upd_idx, lookup_idx;
  logic            accept;

  assign accept     = req_valid_i && (state_q == StIdle);
  assign upd_idx    = pc_q[IdxW+1:2];
  assign lookup_idx = lookup_pc_i[IdxW+1:2];

  // Only the index bits of the fetch PC select a counter.
  logic unused_lookup_bits;
  assign unused_lookup_bits = ^{lookup_pc_i[N-1:IdxW+2], lookup_pc_i[1:0]};

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid_i) state_d = StEval;
      StEval:  state_d = StResp;
      StResp:  if (resp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o  = (state_q == StIdle);
    resp_valid_o = (state_q == StResp);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      imm_q  <= '0;
      ctrl_q <= '0;
      pred_q <= 1'b0;
    end else if (accept) begin
      pc_q   <= req_pc_i;
      a_q    <= req_a_i;
      b_q    <= req_b_i;
      imm_q  <= req_imm_i;
      ctrl_q <= req_ctrl_i;
      pred_q <= req_pred_i;
    end
  end

  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (ctrl_q)
      COMP_EQ:  cond_taken = (a_q == b_q);
      COMP_NE:  cond_taken = (a_q != b_q);
      COMP_LT:  cond_taken = ($signed(a_q) < $signed(b_q));
      COMP_GE:  cond_taken = ($signed(a_q) >= $signed(b_q));
      COMP_LTU: cond_taken = (a_q < b_q);
      COMP_GEU: cond_taken = (a_q >= b_q);
      default:  cond_illegal = 1'b1;
    endcase
  end

  assign target = pc_q + (cond_taken ? imm_q : PcStep);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_taken_q      <= 1'b0;
      resp_target_q     <= '0;
      resp_mispredict_q <= 1'b0;
      resp_illegal_q    <= 1'b0;
    end else if (state_q == StEval) begin
      resp_taken_q      <= cond_taken;
      resp_target_q     <= target;
      resp_mispredict_q <= cond_taken ^ pred_q;
      resp_illegal_q    <= cond_illegal;
    end
  end

  assign resp_taken_o      = resp_taken_q;
  assign resp_target_o     = resp_target_q;
  assign resp_mispredict_o = resp_mispredict_q;
  assign resp_illegal_o    = resp_illegal_q;

  // Counters train once per legal branch, at the edge that leaves EVAL.
  always_comb begin
    bht_d = bht_q;
    if ((state_q == StEval) && !cond_illegal) begin
      if (cond_taken && (bht_q[upd_idx] != 2'b11)) begin
        bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
      end else if (!cond_taken && (bht_q[upd_idx] != 2'b00)) begin
        bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bht_q <= '{default: 2'b01};
    end else begin
      bht_q <= bht_d;
    end
  end

  assign lookup_taken_o = bht_q[lookup_idx][1];

endmodule

// File: tb/tb_branch_sched.sv
// Self-checking bench for branch_sched: directed vector table, hand-written
// backpressure/reset sequences and randomized branches against a reference model.
module tb_branch_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_pc, req_a, req_b, req_imm;
  logic [2:0]  req_ctrl;
  logic        req_pred;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic        resp_valid, resp_ready;
  logic        resp_taken, resp_mispredict, resp_illegal;
  logic [31:0] resp_target;

  int checks = 0;
  int errors = 0;

  int bht_m [16];

  branch_sched #(.N(32), .BHT_ENTRIES(16)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_pc_i          (req_pc),
    .req_a_i           (req_a),
    .req_b_i           (req_b),
    .req_imm_i         (req_imm),
    .req_ctrl_i        (req_ctrl),
    .req_pred_i        (req_pred),
    .lookup_pc_i       (lookup_pc),
    .lookup_taken_o    (lookup_taken),
    .resp_valid_o      (resp_valid),
    .resp_ready_i      (resp_ready),
    .resp_taken_o      (resp_taken),
    .resp_target_o     (resp_target),
    .resp_mispredict_o (resp_mispredict),
    .resp_illegal_o    (resp_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, a, b, imm;
    logic [2:0]  ctrl;
    logic        pred;
    logic        t;
    logic [31:0] tg;
    logic        m;
    logic        il;
  } vec_t;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  function automatic logic model_lookup(input logic [31:0] pc);
    return bht_m[idx_of(pc)] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bht_m[i] = 1;
  endtask

  task automatic model_eval(input logic [31:0] pc, a, b, imm, input logic [2:0] ctrl,
                            input logic pred, output logic t, output logic [31:0] tg,
                            output logic m, output logic il);
    il = (ctrl == 3'd2) || (ctrl == 3'd3);
    case (ctrl)
      3'd0:    t = (a == b);
      3'd1:    t = (a != b);
      3'd4:    t = ($signed(a) < $signed(b));
      3'd5:    t = ($signed(a) >= $signed(b));
      3'd6:    t = (a < b);
      3'd7:    t = (a >= b);
      default: t = 1'b0;
    endcase
    tg = t ? pc + imm : pc + 32'd4;
    m  = (t != pred);
  endtask

  task automatic model_train(input logic [31:0] pc, input logic t, input logic il);
    int i;
    i = idx_of(pc);
    if (!il) begin
      if (t) bht_m[i] = (bht_m[i] < 3) ? bht_m[i] + 1 : 3;
      else   bht_m[i] = (bht_m[i] > 0) ? bht_m[i] - 1 : 0;
    end
  endtask

  task automatic run_branch(input logic [31:0] pc, a, b, imm, input logic [2:0] ctrl,
                            input logic pred, input int hold,
                            output logic t_o, output logic [31:0] tg_o,
                            output logic m_o, output logic il_o);
    logic et, em, eil;
    logic [31:0] etg;
    int n;
    model_eval(pc, a, b, imm, ctrl, pred, et, etg, em, eil);
    @(negedge clk);
    req_valid = 1'b1;
    req_pc = pc; req_a = a; req_b = b; req_imm = imm; req_ctrl = ctrl; req_pred = pred;
    lookup_pc = pc;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check1("req_ready_idle", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check1("eval_resp_valid", resp_valid, 1'b0);
    check1("eval_req_ready", req_ready, 1'b0);
    // Same-cycle lookup must see the counter before this branch trains it.
    check1("lookup_pre_update", lookup_taken, model_lookup(pc));
    model_train(pc, et, eil);
    t_o = 1'b0; tg_o = '0; m_o = 1'b0; il_o = 1'b0;
    for (int c = 0; c <= hold; c++) begin
      @(negedge clk);
      check1("resp_valid", resp_valid, 1'b1);
      check1("resp_req_ready", req_ready, 1'b0);
      check1("resp_taken", resp_taken, et);
      check32("resp_target", resp_target, etg);
      check1("resp_mispredict", resp_mispredict, em);
      check1("resp_illegal", resp_illegal, eil);
      if (c == 0) begin
        t_o = resp_taken; tg_o = resp_target; m_o = resp_mispredict; il_o = resp_illegal;
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check1("post_resp_valid", resp_valid, 1'b0);
    check1("post_req_ready", req_ready, 1'b1);
    check1("lookup_post_update", lookup_taken, model_lookup(pc));
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [11];
    logic        rt, rm, ril;
    logic [31:0] rtg;
    logic [31:0] ra, rb, rpc, rimm;

    vecs[0]  = '{32'h100, 32'd5, 32'd5, 32'h20, 3'd0, 1'b0, 1'b1, 32'h120, 1'b1, 1'b0};
    vecs[1]  = '{32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 3'd4, 1'b1, 1'b1, 32'h210, 1'b0, 1'b0};
    vecs[2]  = '{32'h204, 32'hFFFF_FFFF, 32'd1, 32'h10, 3'd6, 1'b1, 1'b0, 32'h208, 1'b1, 1'b0};
    vecs[3]  = '{32'h300, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 3'd5, 1'b0,
                 1'b1, 32'h2F0, 1'b1, 1'b0};
    vecs[4]  = '{32'h304, 32'd1, 32'hFFFF_FFFF, 32'h8, 3'd7, 1'b0, 1'b0, 32'h308, 1'b0, 1'b0};
    vecs[5]  = '{32'h308, 32'd7, 32'd7, 32'h40, 3'd1, 1'b1, 1'b0, 32'h30C, 1'b1, 1'b0};
    vecs[6]  = '{32'h10, 32'd3, 32'd3, 32'h100, 3'd0, 1'b1, 1'b1, 32'h110, 1'b0, 1'b0};
    vecs[7]  = '{32'h10, 32'd3, 32'd3, 32'h100, 3'd2, 1'b1, 1'b0, 32'h14, 1'b1, 1'b1};
    vecs[8]  = '{32'h10, 32'd3, 32'd3, 32'h100, 3'd3, 1'b0, 1'b0, 32'h14, 1'b0, 1'b1};
    vecs[9]  = '{32'hFFFF_FFF0, 32'd0, 32'd0, 32'h20, 3'd0, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0};
    vecs[10] = '{32'h400, 32'd5, 32'd5, 32'h4, 3'd4, 1'b0, 1'b0, 32'h404, 1'b0, 1'b0};

    rst = 1'b1;
    req_valid = 1'b0; req_pc = '0; req_a = '0; req_b = '0; req_imm = '0;
    req_ctrl = '0; req_pred = 1'b0; lookup_pc = '0; resp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check1("reset_req_ready", req_ready, 1'b1);
    check1("reset_resp_valid", resp_valid, 1'b0);
    check32("reset_resp_target", resp_target, 32'h0);
    check1("reset_resp_taken", resp_taken, 1'b0);
    check1("reset_lookup_pc0", lookup_taken, 1'b0);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      run_branch(vecs[i].pc, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].ctrl, vecs[i].pred, 0,
                 rt, rtg, rm, ril);
      check1($sformatf("vec%0d_taken", i), rt, vecs[i].t);
      check32($sformatf("vec%0d_target", i), rtg, vecs[i].tg);
      check1($sformatf("vec%0d_mispredict", i), rm, vecs[i].m);
      check1($sformatf("vec%0d_illegal", i), ril, vecs[i].il);
    end
    lookup_pc = 32'h100;
    #1 check1("beq_trained_lookup", lookup_taken, 1'b1);
    lookup_pc = 32'h10;
    #1 check1("illegal_bht_unchanged", lookup_taken, 1'b1);

    // Saturation at the top and bottom of a counter
    for (int i = 0; i < 5; i++) run_branch(32'h40, 32'd1, 32'd2, 32'h10, 3'd1, 1'b1, 0,
                                           rt, rtg, rm, ril);
    lookup_pc = 32'h40;
    #1 check1("sat_high_lookup", lookup_taken, 1'b1);
    for (int i = 0; i < 4; i++) run_branch(32'h40, 32'd2, 32'd2, 32'h10, 3'd1, 1'b1, 0,
                                           rt, rtg, rm, ril);
    lookup_pc = 32'h40;
    #1 check1("sat_low_lookup", lookup_taken, 1'b0);
    run_branch(32'h40, 32'd1, 32'd2, 32'h10, 3'd1, 1'b0, 0, rt, rtg, rm, ril);
    lookup_pc = 32'h40;
    #1 check1("sat_low_no_wrap", lookup_taken, 1'b0);

    // Backpressure with a second request held during EVAL/RESP
    @(negedge clk);
    req_valid = 1'b1;
    req_pc = 32'h500; req_a = 32'd9; req_b = 32'd9; req_imm = 32'h40; req_ctrl = 3'd0;
    req_pred = 1'b1;
    @(posedge clk);
    #1;
    req_pc = 32'h504; req_a = 32'd2; req_b = 32'd3; req_imm = 32'h40; req_ctrl = 3'd7;
    req_pred = 1'b0;
    model_train(32'h500, 1'b1, 1'b0);
    @(negedge clk);
    check1("bp_eval_ready", req_ready, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check1("bp_hold_valid", resp_valid, 1'b1);
      check1("bp_hold_ready", req_ready, 1'b0);
      check1("bp_hold_taken", resp_taken, 1'b1);
      check32("bp_hold_target", resp_target, 32'h540);
      check1("bp_hold_mispredict", resp_mispredict, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check1("bp_valid_drop", resp_valid, 1'b0);
    check1("bp_ready_after_hs", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check1("bp_second_accepted", req_ready, 1'b0);
    check1("bp_second_eval_valid", resp_valid, 1'b0);
    @(negedge clk);
    check1("bp_second_valid", resp_valid, 1'b1);
    check1("bp_second_taken", resp_taken, 1'b0);
    check32("bp_second_target", resp_target, 32'h508);
    model_train(32'h504, 1'b0, 1'b0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;

    // Reset while a request is in EVAL
    run_branch(32'h14, 32'd4, 32'd4, 32'h8, 3'd0, 1'b0, 0, rt, rtg, rm, ril);
    run_branch(32'h14, 32'd4, 32'd4, 32'h8, 3'd0, 1'b0, 0, rt, rtg, rm, ril);
    @(negedge clk);
    req_valid = 1'b1;
    req_pc = 32'h14; req_a = 32'd6; req_b = 32'd6; req_imm = 32'h8; req_ctrl = 3'd0;
    req_pred = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check1("rst_eval_no_valid", resp_valid, 1'b0);
      check1("rst_eval_ready", req_ready, 1'b1);
    end
    check32("rst_eval_target", resp_target, 32'h0);
    check1("rst_eval_taken", resp_taken, 1'b0);
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'(i) << 2;
      #1 check1($sformatf("rst_bht_idx%0d", i), lookup_taken, model_lookup(lookup_pc));
    end
    run_branch(32'h14, 32'd4, 32'd4, 32'h8, 3'd0, 1'b0, 0, rt, rtg, rm, ril);
    lookup_pc = 32'h14;
    #1 check1("rst_bht_weak_nt", lookup_taken, 1'b1);

    // Randomized branches against the model
    for (int k = 0; k < 150; k++) begin
      ra   = rand_op();
      rb   = ($urandom_range(0, 3) == 0) ? ra : rand_op();
      rpc  = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 3)) << 2);
      rimm = $urandom & 32'hFFFF_FFFE;
      run_branch(rpc, ra, rb, rimm, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)), rt, rtg, rm, ril);
      lookup_pc = $urandom;
      #1 check1("rand_lookup", lookup_taken, model_lookup(lookup_pc));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_sched.md
# branch_sched

Multi-cycle branch resolution sequencer for the RV32I core. It accepts one conditional-branch request at a time over a valid/ready handshake and evaluates the condition with an internal comparator that uses the `COMP_*` encodings from `defs.sv`. It computes the next PC, checks the result against a 2-bit saturating-counter branch history table (BHT), and returns taken, target and mispredict over a second valid/ready handshake. The fetch stage reads the same BHT through a combinational lookup port.

## Interface
- N, 32, datapath and PC width
- BHT_ENTRIES, 16, number of 2-bit counters; power of two, ≥2
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  branch request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_pc  in  N  PC of the branch instruction
- req_a, req_b  in  N each  rs1 and rs2 operand values
- req_imm  in  N  sign-extended B-type offset
- req_ctrl  in  3  `COMP_*` code: EQ=000, NE=001, LT=100, GE=101, LTU=110, GEU=111
- req_pred  in  1  direction fetch predicted for this branch
- lookup_pc  in  N  fetch PC for prediction
- lookup_taken  out  1  MSB of the BHT counter indexed by lookup_pc (combinational)
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts the result
- resp_taken  out  1  resolved direction
- resp_target  out  N  resolved next PC
- resp_mispredict  out  1  resp_taken ≠ latched req_pred
- resp_illegal  out  1  req_ctrl was 010 or 011

## Operation
- FSM states and transitions:
  - IDLE → EVAL on req_valid & req_ready. The block latches pc, a, b, imm, ctrl and pred.
  - EVAL → RESP unconditionally.
  - RESP → IDLE on resp_valid & resp_ready. RESP holds while resp_ready is low.
- Comparison in EVAL uses the latched operands:
  - EQ: a == b. NE: a != b.
  - LT and GE: two's-complement signed compare of a and b. The signed view applies to both operands.
  - LTU and GEU: unsigned compare of a and b.
- Codes 010 and 011 give taken=0 and illegal=1. They cause no BHT update, and mispredict equals pred.
- Target is pc+imm if taken, else pc+4. The addition is N bits wide and wraps modulo 2^N; there is no overflow flag.
- BHT index is pc[2+log2(BHT_ENTRIES)-1 : 2], applied to both the latched pc and lookup_pc.
- BHT update happens at the clock edge that ends EVAL, for legal codes only:
  - taken: counter increments, saturating at 11.
  - not taken: counter decrements, saturating at 00.
- Response fields are registered at the end of EVAL. They stay stable for the whole of RESP.

## Timing
- Reset (asynchronous, any time, including mid-EVAL or mid-RESP):
  - state goes to IDLE and every BHT counter goes to 01 (weakly not taken).
  - req_ready=1 once reset deasserts.
  - resp_valid, resp_taken, resp_mispredict and resp_illegal are 0; resp_target is 0.
  - an in-flight request is dropped with no response.
- Latency: a request accepted at edge k has resp_valid high from the cycle after edge k+1. It completes no earlier than edge k+2.
- Throughput: at most one request every 3 cycles when resp_ready is held high.
- req_ready is low in EVAL and RESP. Requests presented then are not accepted, and the requester must hold them.
- resp_valid deasserts in the cycle after the response handshake. IDLE can accept a new request that same cycle.
- lookup_taken is combinational from the current BHT. When a lookup and an update hit the same index in the same cycle, the lookup returns the pre-update value.

## Test plan
- Reset → req_ready=1 and resp_valid=0. lookup_pc=0x0 → lookup_taken=0 (counter 01).
- BEQ: a=5, b=5, pc=0x100, imm=0x20, pred=0 → resp_valid 2 cycles after acceptance with taken=1, target=0x120, mispredict=1. Index 0 counter becomes 10, so lookup_taken=1 at pc=0x100.
- BLT vs BLTU: a=0xFFFFFFFF, b=1. BLT → taken=1. BLTU → taken=0, target=pc+4.
- Saturation: 4× BNE with a=1, b=2 at pc=0x40 → counter reaches 11, and a 5th taken branch keeps it at 11. Then 4 not-taken branches → 00, and lookup_taken=0.
- Backpressure: resp_ready=0 for 5 cycles → outputs hold, req_ready stays 0, and a second req_valid is not accepted. It is accepted in the cycle after the response handshake.
- Illegal and reset: req_ctrl=010 → illegal=1, taken=0, BHT unchanged. Reset asserted during EVAL → no resp_valid, and the BHT returns to all 01.
